// File: rtl/modn_counter_7seg.sv
// modn_counter_7seg: modulo-N up/down counter with prescaler, load and registered 2-digit 7-seg driver
module modn_counter_7seg #(
  parameter int MOD = 12,
  parameter int PRESCALE = 1,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit BLANK_LZ = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [6:0] load_val,
  output logic [6:0] count,
  output logic       wrap,
  output logic [7:0] led,
  output logic [6:0] lseg,
  output logic [6:0] hseg
);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [6:0] TOP = 7'(MOD - 1);
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);
  localparam logic [6:0] INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] enc(input logic [6:0] d);
    case (d)
      7'd0: enc = 7'h3F;
      7'd1: enc = 7'h06;
      7'd2: enc = 7'h5B;
      7'd3: enc = 7'h4F;
      7'd4: enc = 7'h66;
      7'd5: enc = 7'h6D;
      7'd6: enc = 7'h7D;
      7'd7: enc = 7'h07;
      7'd8: enc = 7'h7F;
      default: enc = 7'h6F;
    endcase
  endfunction

  logic [PW-1:0] pre;
  logic          step;
  logic [6:0]    tens, ones, lseg_d, hseg_d;

  always_comb begin
    step = en & (pre == PTOP);
    tens = count / 7'd10;
    ones = count % 7'd10;
    lseg_d = enc(ones) ^ INV;
    hseg_d = (BLANK_LZ && tens == 7'd0) ? INV : enc(tens) ^ INV;
  end

  assign led = {wrap, count};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wrap  <= 1'b0;
      pre   <= '0;
      lseg  <= enc(7'd0) ^ INV;
      hseg  <= BLANK_LZ ? INV : enc(7'd0) ^ INV;
    end else begin
      lseg <= lseg_d;
      hseg <= hseg_d;
      if (load) begin
        count <= (load_val > TOP) ? TOP : load_val;
        pre   <= '0;
        wrap  <= 1'b0;
      end else if (step) begin
        pre   <= '0;
        wrap  <= up_dn ? (count == TOP) : (count == 7'd0);
        count <= up_dn ? ((count == TOP) ? 7'd0 : count + 7'd1)
                       : ((count == 7'd0) ? TOP : count - 7'd1);
      end else begin
        pre  <= en ? pre + 1'b1 : pre;
        wrap <= 1'b0;
      end
    end
  end
endmodule
